bus_xbar: RTL and testbench

Parametrised NUM_MASTERS x NUM_SLAVES crossbar for the valid/ready memory bus (valid, instr, addr, wdata, wstrb -> rdata, ready). It replaces the fixed two-master SoC address decoder with these additions:
- a parameter-driven address map;
- per-master pending buffers, so requests that lose arbitration are replayed instead of dropped;
- selectable fixed-priority or round-robin arbitration;
- an error response for unmapped addresses.
It sits between the cpu ports (imemory = master 0, dmemory = master 1) and the rom/uart/clint/avl slaves.

---
 rtl/bus_xbar.sv | 207 ++++++++++++++++++++
 tb/tb_bus_xbar.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xbar.sv
// NUM_MASTERS x NUM_SLAVES crossbar for the valid/ready memory bus: address decode,
// per-master replay buffers, per-slave arbitration and decode-error responses.
module bus_xbar #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
    {32'h80000000, 32'h02000000, 32'h10000000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_TOP =
    {32'h90000000, 32'h020C0000, 32'h10001000, 32'h00010000},
  parameter int ARB_MODE = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_MASTERS-1:0]     m_valid,
  input  logic [NUM_MASTERS-1:0]     m_instr,
  input  logic [NUM_MASTERS*32-1:0]  m_addr,
  input  logic [NUM_MASTERS*32-1:0]  m_wdata,
  input  logic [NUM_MASTERS*4-1:0]   m_wstrb,
  output logic [NUM_MASTERS*32-1:0]  m_rdata,
  output logic [NUM_MASTERS-1:0]     m_ready,
  output logic [NUM_MASTERS-1:0]     m_error,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [NUM_SLAVES-1:0]      s_instr,
  output logic [NUM_SLAVES*32-1:0]   s_addr,
  output logic [NUM_SLAVES*32-1:0]   s_wdata,
  output logic [NUM_SLAVES*4-1:0]    s_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Returns {hit, index}; scanning downwards lets the lowest matching slave win.
  function automatic logic [SW:0] decode(input logic [31:0] addr);
    logic [SW:0] r;
    r = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--)
      if (addr >= SLAVE_BASE[s*32 +: 32] && addr < SLAVE_TOP[s*32 +: 32])
        r = {1'b1, SW'(s)};
    return r;
  endfunction

  logic [1:0]    state      [NUM_MASTERS];
  logic [SW-1:0] tgt_q      [NUM_MASTERS];
  logic          pend_instr [NUM_MASTERS];
  logic [31:0]   pend_addr  [NUM_MASTERS];
  logic [31:0]   pend_wdata [NUM_MASTERS];
  logic [3:0]    pend_wstrb [NUM_MASTERS];

  logic          busy   [NUM_SLAVES];
  logic [MW-1:0] owner  [NUM_SLAVES];
  logic [MW-1:0] rr_ptr [NUM_SLAVES];

  logic          dec_hit   [NUM_MASTERS];
  logic [SW-1:0] dec_idx   [NUM_MASTERS];
  logic          req       [NUM_MASTERS];
  logic [SW-1:0] req_tgt   [NUM_MASTERS];
  logic          req_instr [NUM_MASTERS];
  logic [31:0]   req_addr  [NUM_MASTERS];
  logic [31:0]   req_wdata [NUM_MASTERS];
  logic [3:0]    req_wstrb [NUM_MASTERS];
  logic          granted   [NUM_MASTERS];
  logic          gnt_s     [NUM_SLAVES];
  logic [MW-1:0] win       [NUM_SLAVES];

  // Request view: a PEND buffer and a fresh IDLE request compete on equal terms.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      {dec_hit[m], dec_idx[m]} = decode(m_addr[m*32 +: 32]);
      if (state[m] == ST_PEND) begin
        req[m]       = 1'b1;
        req_tgt[m]   = tgt_q[m];
        req_instr[m] = pend_instr[m];
        req_addr[m]  = pend_addr[m];
        req_wdata[m] = pend_wdata[m];
        req_wstrb[m] = pend_wstrb[m];
      end else begin
        req[m]       = m_valid[m] && (state[m] == ST_IDLE) && dec_hit[m];
        req_tgt[m]   = dec_idx[m];
        req_instr[m] = m_instr[m];
        req_addr[m]  = m_addr[m*32 +: 32];
        req_wdata[m] = m_wdata[m*32 +: 32];
        req_wstrb[m] = m_wstrb[m*4 +: 4];
      end
    end
  end

  // A slave is grantable when idle or when its current response lands this cycle.
  always_comb begin
    int c;
    c = 0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      gnt_s[s] = 1'b0;
      win[s]   = '0;
      if (!busy[s] || s_ready[s]) begin
        if (ARB_MODE == 0) begin
          for (int m = 0; m < NUM_MASTERS; m++)
            if (req[m] && req_tgt[m] == SW'(s)) begin
              gnt_s[s] = 1'b1;
              win[s]   = MW'(m);
            end
        end else begin
          for (int k = NUM_MASTERS; k >= 1; k--) begin
            c = (int'(rr_ptr[s]) + k) % NUM_MASTERS;
            if (req[c] && req_tgt[c] == SW'(s)) begin
              gnt_s[s] = 1'b1;
              win[s]   = MW'(c);
            end
          end
        end
      end
    end
    for (int m = 0; m < NUM_MASTERS; m++) granted[m] = 1'b0;
    for (int s = 0; s < NUM_SLAVES; s++)
      if (gnt_s[s]) granted[win[s]] = 1'b1;
  end

  always_comb begin
    s_valid = '0;
    s_instr = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int s = 0; s < NUM_SLAVES; s++)
      if (gnt_s[s]) begin
        s_valid[s]          = 1'b1;
        s_instr[s]          = req_instr[win[s]];
        s_addr[s*32 +: 32]  = req_addr[win[s]] - SLAVE_BASE[s*32 +: 32];
        s_wdata[s*32 +: 32] = req_wdata[win[s]];
        s_wstrb[s*4 +: 4]   = req_wstrb[win[s]];
      end
  end

  always_comb begin
    m_ready = '0;
    m_error = '0;
    m_rdata = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (state[m] == ST_WAIT && s_ready[tgt_q[m]] && busy[tgt_q[m]] &&
          owner[tgt_q[m]] == MW'(m)) begin
        m_ready[m]          = 1'b1;
        m_rdata[m*32 +: 32] = s_rdata[int'(tgt_q[m])*32 +: 32];
      end else if (state[m] == ST_ERR) begin
        m_ready[m] = 1'b1;
        m_error[m] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        state[m]      <= ST_IDLE;
        tgt_q[m]      <= '0;
        pend_instr[m] <= 1'b0;
        pend_addr[m]  <= '0;
        pend_wdata[m] <= '0;
        pend_wstrb[m] <= '0;
      end
      for (int s = 0; s < NUM_SLAVES; s++) begin
        busy[s]   <= 1'b0;
        owner[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        case (state[m])
          ST_IDLE:
            if (m_valid[m]) begin
              if (!dec_hit[m]) begin
                state[m] <= ST_ERR;
              end else begin
                tgt_q[m] <= dec_idx[m];
                if (granted[m]) begin
                  state[m] <= ST_WAIT;
                end else begin
                  state[m]      <= ST_PEND;
                  pend_instr[m] <= m_instr[m];
                  pend_addr[m]  <= m_addr[m*32 +: 32];
                  pend_wdata[m] <= m_wdata[m*32 +: 32];
                  pend_wstrb[m] <= m_wstrb[m*4 +: 4];
                end
              end
            end
          ST_PEND: if (granted[m]) state[m] <= ST_WAIT;
          ST_WAIT: if (m_ready[m]) state[m] <= ST_IDLE;
          default: state[m] <= ST_IDLE;
        endcase
      end
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (gnt_s[s]) begin
          busy[s]   <= 1'b1;
          owner[s]  <= win[s];
          rr_ptr[s] <= win[s];
        end else if (s_ready[s]) begin
          busy[s] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_xbar.sv
// Directed bench for bus_xbar: one fixed-priority and one round-robin instance
// driven by the same stimulus, with hand-computed expectations.
module tb_bus_xbar;
  localparam int M = 2;
  localparam int S = 4;

  logic clock = 1'b0;
  logic reset;
  logic [M-1:0]    m_valid, m_instr;
  logic [M*32-1:0] m_addr, m_wdata;
  logic [M*4-1:0]  m_wstrb;
  logic [S*32-1:0] s_rdata;
  logic [S-1:0]    s_ready;

  logic [M*32-1:0] m_rdata0, m_rdata1;
  logic [M-1:0]    m_ready0, m_ready1, m_error0, m_error1;
  logic [S-1:0]    s_valid0, s_valid1, s_instr0, s_instr1;
  logic [S*32-1:0] s_addr0, s_addr1, s_wdata0, s_wdata1;
  logic [S*4-1:0]  s_wstrb0, s_wstrb1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  bus_xbar #(.ARB_MODE(0)) dut0 (
    .clock(clock), .reset(reset),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata0), .m_ready(m_ready0), .m_error(m_error0),
    .s_valid(s_valid0), .s_instr(s_instr0), .s_addr(s_addr0), .s_wdata(s_wdata0),
    .s_wstrb(s_wstrb0), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  bus_xbar #(.ARB_MODE(1)) dut1 (
    .clock(clock), .reset(reset),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata1), .m_ready(m_ready1), .m_error(m_error1),
    .s_valid(s_valid1), .s_instr(s_instr1), .s_addr(s_addr1), .s_wdata(s_wdata1),
    .s_wstrb(s_wstrb1), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    m_valid = '0;
    s_ready = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = '0;
    tick();
    tick();
    #1;
    chk("rst_m_ready", 64'(m_ready0), 64'h0);
    chk("rst_m_error", 64'(m_error0), 64'h0);
    chk("rst_m_rdata", 64'(m_rdata0), 64'h0);
    chk("rst_s_valid", 64'(s_valid0), 64'h0);
    chk("rst_s_addr_hi", 64'(s_addr0[127:64]), 64'h0);
    chk("rst_s_valid_rr", 64'(s_valid1), 64'h0);
    reset = 1'b1;

    // single read from the uart window
    tick();
    m_valid = 2'b10; m_addr[32 +: 32] = 32'h10000004;
    #1;
    chk("rd_s_valid", 64'(s_valid0), 64'h2);
    chk("rd_s_addr", 64'(s_addr0[32 +: 32]), 64'h4);
    chk("rd_no_ready", 64'(m_ready0), 64'h0);
    tick();
    m_valid = '0;
    #1;
    chk("rd_wait_s_valid", 64'(s_valid0), 64'h0);
    tick();
    s_ready = 4'b0010; s_rdata[32 +: 32] = 32'hA5;
    #1;
    chk("rd_m_ready", 64'(m_ready0), 64'h2);
    chk("rd_m_rdata", 64'(m_rdata0[32 +: 32]), 64'hA5);
    chk("rd_m_error", 64'(m_error0), 64'h0);
    tick();
    s_ready = '0;
    #1;
    chk("rd_ready_pulse", 64'(m_ready0), 64'h0);

    // contention on slave 3: master 1 first, master 0 replayed from its buffer
    tick();
    m_valid = 2'b11; m_instr = 2'b01;
    m_addr[0 +: 32] = 32'h80000010; m_addr[32 +: 32] = 32'h80000020;
    m_wdata[0 +: 32] = 32'hDEADBEEF; m_wstrb[0 +: 4] = 4'hF;
    #1;
    chk("arb_s_valid", 64'(s_valid0), 64'h8);
    chk("arb_s_addr_m1", 64'(s_addr0[96 +: 32]), 64'h20);
    chk("arb_s_wstrb_m1", 64'(s_wstrb0[12 +: 4]), 64'h0);
    tick();
    m_valid = '0; m_instr = '0; m_wdata = '0; m_wstrb = '0;
    #1;
    chk("arb_busy_s_valid", 64'(s_valid0), 64'h0);
    tick();
    s_ready = 4'b1000; s_rdata[96 +: 32] = 32'h111;
    #1;
    chk("arb_m1_ready", 64'(m_ready0), 64'h2);
    chk("arb_m1_rdata", 64'(m_rdata0[32 +: 32]), 64'h111);
    chk("arb_b2b_s_valid", 64'(s_valid0), 64'h8);
    chk("arb_s_addr_m0", 64'(s_addr0[96 +: 32]), 64'h10);
    chk("arb_pend_wdata", 64'(s_wdata0[96 +: 32]), 64'hDEADBEEF);
    chk("arb_pend_wstrb", 64'(s_wstrb0[12 +: 4]), 64'hF);
    chk("arb_pend_instr", 64'(s_instr0), 64'h8);
    tick();
    s_ready = '0;
    #1;
    chk("arb_idle_ready", 64'(m_ready0), 64'h0);
    chk("arb_idle_s_valid", 64'(s_valid0), 64'h0);
    tick();
    s_ready = 4'b1000; s_rdata[96 +: 32] = 32'h222;
    #1;
    chk("arb_m0_ready", 64'(m_ready0), 64'h1);
    chk("arb_m0_rdata", 64'(m_rdata0), 64'h222);
    tick();
    s_ready = '0;

    // unmapped addresses, including the exclusive top of slave 0
    tick();
    m_valid = 2'b11; m_addr[0 +: 32] = 32'h40000000; m_addr[32 +: 32] = 32'h00010000;
    #1;
    chk("err_no_s_valid", 64'(s_valid0), 64'h0);
    chk("err_not_yet", 64'(m_ready0), 64'h0);
    tick();
    m_valid = '0;
    #1;
    chk("err_m_ready", 64'(m_ready0), 64'h3);
    chk("err_m_error", 64'(m_error0), 64'h3);
    chk("err_m_rdata", 64'(m_rdata0), 64'h0);
    chk("err_s_valid", 64'(s_valid0), 64'h0);
    tick();
    chk("err_pulse", 64'(m_ready0), 64'h0);
    chk("err_pulse_err", 64'(m_error0), 64'h0);

    // parallel transactions to two slaves at window edges
    tick();
    m_valid = 2'b11; m_addr[0 +: 32] = 32'h0000FFFC; m_addr[32 +: 32] = 32'h02000000;
    #1;
    chk("par_s_valid", 64'(s_valid0), 64'h5);
    chk("par_s_addr0", 64'(s_addr0[0 +: 32]), 64'hFFFC);
    chk("par_s_addr2", 64'(s_addr0[64 +: 32]), 64'h0);
    tick();
    m_valid = '0;
    tick();
    s_ready = 4'b0100; s_rdata[64 +: 32] = 32'h33;
    #1;
    chk("par_m1_ready", 64'(m_ready0), 64'h2);
    chk("par_m1_rdata", 64'(m_rdata0[32 +: 32]), 64'h33);
    tick();
    s_ready = 4'b0001; s_rdata[0 +: 32] = 32'h44;
    #1;
    chk("par_m0_ready", 64'(m_ready0), 64'h1);
    chk("par_m0_rdata", 64'(m_rdata0[0 +: 32]), 64'h44);
    tick();
    s_ready = '0;

    // round-robin on slave 3 (checked on the ARB_MODE 1 instance)
    do_reset();
    tick();
    m_valid = 2'b11; m_addr[0 +: 32] = 32'h80000000; m_addr[32 +: 32] = 32'h80000004;
    #1;
    chk("rr_g1_valid", 64'(s_valid1), 64'h8);
    chk("rr_g1_m1", 64'(s_addr1[96 +: 32]), 64'h4);
    tick();
    m_valid = '0; s_ready = 4'b1000; s_rdata[96 +: 32] = 32'h51;
    #1;
    chk("rr_r1_ready", 64'(m_ready1), 64'h2);
    chk("rr_g2_m0", 64'(s_addr1[96 +: 32]), 64'h0);
    chk("rr_g2_valid", 64'(s_valid1), 64'h8);
    tick();
    m_valid = 2'b10; s_ready = 4'b1000; s_rdata[96 +: 32] = 32'h52;
    #1;
    chk("rr_r2_ready", 64'(m_ready1), 64'h1);
    chk("rr_r2_rdata", 64'(m_rdata1[0 +: 32]), 64'h52);
    chk("rr_g3_m1", 64'(s_addr1[96 +: 32]), 64'h4);
    tick();
    m_valid = 2'b01; s_ready = '0;
    #1;
    chk("rr_busy", 64'(s_valid1), 64'h0);
    tick();
    m_valid = '0; s_ready = 4'b1000;
    #1;
    chk("rr_r3_ready", 64'(m_ready1), 64'h2);
    chk("rr_g4_m0", 64'(s_addr1[96 +: 32]), 64'h0);
    tick();
    m_valid = 2'b10; s_ready = 4'b1000;
    #1;
    chk("rr_r4_ready", 64'(m_ready1), 64'h1);
    chk("rr_g5_m1", 64'(s_addr1[96 +: 32]), 64'h4);
    tick();
    m_valid = '0; s_ready = 4'b1000;
    #1;
    chk("rr_r5_ready", 64'(m_ready1), 64'h2);
    chk("rr_r5_no_grant", 64'(s_valid1), 64'h0);
    tick();
    m_valid = 2'b11; s_ready = '0;
    #1;
    chk("rr_tie_m0", 64'(s_addr1[96 +: 32]), 64'h0);
    chk("fixed_tie_m1", 64'(s_addr0[96 +: 32]), 64'h4);

    // reset while master 1 waits on slave 3
    do_reset();
    tick();
    m_valid = 2'b10; m_addr[32 +: 32] = 32'h80000008;
    #1;
    chk("rst_wait_issue", 64'(s_valid0), 64'h8);
    chk("rst_wait_addr", 64'(s_addr0[96 +: 32]), 64'h8);
    tick();
    m_valid = '0; reset = 1'b0;
    tick();
    reset = 1'b1; s_ready = 4'b1000; s_rdata[96 +: 32] = 32'h77;
    #1;
    chk("rst_drop_ready", 64'(m_ready0), 64'h0);
    chk("rst_drop_ready_rr", 64'(m_ready1), 64'h0);
    chk("rst_drop_s_valid", 64'(s_valid0), 64'h0);
    tick();
    s_ready = '0; m_valid = 2'b10;
    #1;
    chk("rst_fresh_valid", 64'(s_valid0), 64'h8);
    chk("rst_fresh_addr", 64'(s_addr0[96 +: 32]), 64'h8);
    tick();
    m_valid = '0;
    tick();
    s_ready = 4'b1000; s_rdata[96 +: 32] = 32'h88;
    #1;
    chk("rst_fresh_ready", 64'(m_ready0), 64'h2);
    chk("rst_fresh_rdata", 64'(m_rdata0[32 +: 32]), 64'h88);
    chk("rst_fresh_error", 64'(m_error0), 64'h0);
    tick();
    s_ready = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
